// File: rtl/j1_pkg.sv
// Shared definitions for the J1 I/O bridge: I/O address map, status and
// control bit positions, and the core request bundle.
package j1_pkg;

  // I/O page: any address with [15:12] == 4'hF
  localparam logic [3:0]  IO_PAGE   = 4'hF;

  localparam logic [15:0] IO_TX     = 16'hF000;
  localparam logic [15:0] IO_RX     = 16'hF001;
  localparam logic [15:0] IO_RXCLR  = 16'hF002;
  localparam logic [15:0] IO_STATUS = 16'hF003;
  localparam logic [15:0] IO_TIMER  = 16'hF004;
  localparam logic [15:0] IO_TGN    = 16'hF005;
  localparam logic [15:0] IO_CTRL   = 16'hF006;

  // Status register bit indices
  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_TX_OVF   = 3;

  // Control register bit indices
  localparam int CT_IE_RX       = 0;
  localparam int CT_IE_TX_EMPTY = 1;
  localparam int CTRL_W         = 2;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
  } core_req_t;

  // True when the address falls in the I/O page rather than RAM
  function automatic logic is_io(input logic [15:0] addr);
    return addr[15:12] == IO_PAGE;
  endfunction

endpackage

// File: rtl/j1_sync_fifo.sv
// Single-clock FIFO with combinational head output. Pushes while full and
// pops while empty are ignored; DEPTH must be a power of two so the pointers
// wrap naturally.
module j1_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full/empty are judged on the count at cycle start
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; clearing the pointers discards the contents
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/j1_io_bridge.sv
// J1 core memory/I-O bridge: aliased 16-bit RAM, TX FIFO, RX holding
// register, cycle counter, TGN and control registers, level interrupt.
// Every read is registered so core_rdata reflects the previous cycle's address.
module j1_io_bridge
  import j1_pkg::*;
#(
  parameter int RAM_AW   = 12,
  parameter int TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] core_addr,
  input  logic [15:0] core_wdata,
  input  logic        core_we,
  output logic [15:0] core_rdata,
  output logic [15:0] tgn_reg,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam int CW = $clog2(TX_DEPTH + 1);

  core_req_t req;
  assign req = '{addr: core_addr, wdata: core_wdata, we: core_we};

  // Address decode
  logic req_io;
  logic wr_tx, wr_rxclr, wr_status, wr_tgn, wr_ctrl, ram_we;

  assign req_io    = is_io(req.addr);
  assign wr_tx     = req.we & (req.addr == IO_TX);
  assign wr_rxclr  = req.we & (req.addr == IO_RXCLR);
  assign wr_status = req.we & (req.addr == IO_STATUS);
  assign wr_tgn    = req.we & (req.addr == IO_TGN);
  assign wr_ctrl   = req.we & (req.addr == IO_CTRL);
  // RAM is left untouched while reset is held
  assign ram_we    = req.we & ~req_io & ~reset;

  // TX FIFO
  logic [CW-1:0] tx_count;
  logic          tx_full, tx_empty, tx_pop;

  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;

  j1_sync_fifo #(
    .WIDTH (16),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_tx),
    .wdata_i (req.wdata),
    .pop_i   (tx_pop),
    .rdata_o (tx_data),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  // Register state
  logic              tx_ovf_q, tx_ovf_d;
  logic              rx_full_q, rx_full_d;
  logic [15:0]       rx_hold_q, rx_hold_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [15:0]       tgn_q, tgn_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              irq_q, irq_d;
  logic [15:0]       io_rd_q, io_rd_d;
  logic              sel_ram_q, sel_ram_d;
  logic [15:0]       status;
  logic              rx_accept;

  assign rx_ready  = ~rx_full_q;
  assign rx_accept = rx_valid & ~rx_full_q;

  always_comb begin
    status              = '0;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_FULL]  = rx_full_q;
    status[ST_TX_OVF]   = tx_ovf_q;
  end

  // Next-state for the I/O registers and the I/O read mux
  always_comb begin
    tx_ovf_d  = tx_ovf_q;
    rx_full_d = rx_full_q;
    rx_hold_d = rx_hold_q;
    ctrl_d    = ctrl_q;
    tgn_d     = tgn_q;
    cnt_d     = cnt_q + 16'd1;
    sel_ram_d = ~req_io;
    io_rd_d   = '0;

    // A dropped push sets overflow even if a pop frees a slot this cycle
    if (wr_tx & tx_full)                        tx_ovf_d = 1'b1;
    else if (wr_status & req.wdata[ST_TX_OVF])  tx_ovf_d = 1'b0;

    // Accept only happens while empty, so a clear never races a new word
    if (rx_accept) begin
      rx_full_d = 1'b1;
      rx_hold_d = rx_data;
    end else if (wr_rxclr) begin
      rx_full_d = 1'b0;
    end

    if (wr_ctrl) ctrl_d = req.wdata[CTRL_W-1:0];
    if (wr_tgn)  tgn_d  = req.wdata;

    irq_d = (rx_full_q & ctrl_q[CT_IE_RX]) | (tx_empty & ctrl_q[CT_IE_TX_EMPTY]);

    case (req.addr)
      IO_TX:     io_rd_d = 16'(tx_count);
      IO_RX:     io_rd_d = rx_hold_q;
      IO_STATUS: io_rd_d = status;
      IO_TIMER:  io_rd_d = cnt_q;
      IO_TGN:    io_rd_d = tgn_q;
      IO_CTRL:   io_rd_d = 16'(ctrl_q);
      default:   io_rd_d = '0;
    endcase
  end

  // I/O registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf_q  <= 1'b0;
      rx_full_q <= 1'b0;
      rx_hold_q <= '0;
      ctrl_q    <= '0;
      tgn_q     <= '0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
      io_rd_q   <= '0;
      sel_ram_q <= 1'b0;
    end else begin
      tx_ovf_q  <= tx_ovf_d;
      rx_full_q <= rx_full_d;
      rx_hold_q <= rx_hold_d;
      ctrl_q    <= ctrl_d;
      tgn_q     <= tgn_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
      io_rd_q   <= io_rd_d;
      sel_ram_q <= sel_ram_d;
    end
  end

  // Read-first RAM; upper address bits are ignored so the RAM aliases
  logic [15:0]       ram_q [2**RAM_AW];
  logic [15:0]       ram_rd_q;
  logic [RAM_AW-1:0] ram_idx;

  assign ram_idx = req.addr[RAM_AW-1:0];

  // RAM write and registered read of the old word
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= req.wdata;
    ram_rd_q <= ram_q[ram_idx];
  end

  // sel_ram_q is cleared by reset, so core_rdata reads 0 during reset
  assign core_rdata = sel_ram_q ? ram_rd_q : io_rd_q;
  assign tgn_reg    = tgn_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_j1_io_bridge.sv
// Bench for j1_io_bridge: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the address map.
module tb_j1_io_bridge;

  localparam int TXD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] core_addr, core_wdata, core_rdata, tgn_reg, tx_data, rx_data;
  logic        core_we, tx_valid, tx_ready, rx_valid, rx_ready, irq;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  j1_io_bridge #(.RAM_AW(12), .TX_DEPTH(TXD)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_we    (core_we),
    .core_rdata (core_rdata),
    .tgn_reg    (tgn_reg),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .irq        (irq)
  );

  // Behavioural model state
  logic [15:0] m_ram [4096];
  logic [15:0] txq [$];
  logic        m_ovf, m_rxf, m_irq;
  logic [15:0] m_hold, m_tgn, m_cnt, m_rd;
  logic [1:0]  m_ctrl;

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (a[15:12] != 4'hF) return m_ram[a[11:0]];
    case (a)
      16'hF000: return 16'(txq.size());
      16'hF001: return m_hold;
      16'hF003: return {12'd0, m_ovf, m_rxf, txq.size() == TXD, txq.size() == 0};
      16'hF004: return m_cnt;
      16'hF005: return m_tgn;
      16'hF006: return {14'd0, m_ctrl};
      default:  return 16'h0000;
    endcase
  endfunction

  // Advance model by one clock using the current inputs, then step the DUT
  task automatic cycle();
    logic [15:0] rd;
    logic        irq_n;
    int          sz;
    sz = txq.size();
    if (reset) begin
      m_rd = 0; m_tgn = 0; m_irq = 0; m_ctrl = 0; m_cnt = 0;
      txq.delete(); m_ovf = 0; m_rxf = 0; m_hold = 0;
    end else begin
      rd    = m_read(core_addr);
      irq_n = (m_rxf & m_ctrl[0]) | ((sz == 0) & m_ctrl[1]);
      if (sz > 0 && tx_ready) void'(txq.pop_front());
      if (core_we && core_addr == 16'hF000) begin
        if (sz < TXD) txq.push_back(core_wdata);
        else          m_ovf = 1'b1;
      end
      if (core_we && core_addr == 16'hF003 && core_wdata[3]) m_ovf = 1'b0;
      if (rx_valid && !m_rxf) begin
        m_rxf = 1'b1; m_hold = rx_data;
      end else if (core_we && core_addr == 16'hF002) begin
        m_rxf = 1'b0;
      end
      if (core_we && core_addr == 16'hF005) m_tgn = core_wdata;
      if (core_we && core_addr == 16'hF006) m_ctrl = core_wdata[1:0];
      if (core_we && core_addr[15:12] != 4'hF) m_ram[core_addr[11:0]] = core_wdata;
      m_cnt = m_cnt + 16'd1;
      m_rd  = rd;
      m_irq = irq_n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w);
    core_addr = a; core_wdata = d; core_we = w;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(16'hF00F, 16'h0, 1'b0);
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 16'h0;
    cycle(); cycle(); cycle();
    n_vec++; if (core_rdata !== 16'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0000", core_rdata); end
    n_vec++; if (tgn_reg !== 16'h0) begin n_err++; $display("FAIL reset_tgn: got %h want 0000", tgn_reg); end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_txvalid: got %b want 0", tx_valid); end
    n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rxready: got %b want 1", rx_ready); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    reset = 1'b0;
  endtask

  task automatic test_ram_alias();
    drive(16'h0005, 16'h1234, 1'b1); cycle();
    drive(16'h1005, 16'h0, 1'b0);    cycle();
    n_vec++; if (core_rdata !== 16'h1234) begin n_err++; $display("FAIL ram_alias: got %h want 1234", core_rdata); end
    // write and read same address: old data comes back
    drive(16'h2005, 16'h5678, 1'b1); cycle();
    n_vec++; if (core_rdata !== 16'h1234) begin n_err++; $display("FAIL ram_read_first: got %h want 1234", core_rdata); end
    drive(16'h0005, 16'h0, 1'b0);    cycle();
    n_vec++; if (core_rdata !== 16'h5678) begin n_err++; $display("FAIL ram_new: got %h want 5678", core_rdata); end
  endtask

  task automatic test_tx_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(16'hF000, 16'h00A0 + 16'(i), 1'b1); cycle(); end
    drive(16'hF000, 16'h0, 1'b0); cycle();
    n_vec++; if (core_rdata !== 16'h0004) begin n_err++; $display("FAIL tx_count_full: got %h want 0004", core_rdata); end
    drive(16'hF003, 16'h0, 1'b0); cycle();
    n_vec++; if (core_rdata !== 16'h000A) begin n_err++; $display("FAIL tx_status_ovf: got %h want 000a", core_rdata); end
    drive(16'hF00F, 16'h0, 1'b0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (tx_valid !== 1'b1 || tx_data !== 16'h00A0 + 16'(i)) begin
        n_err++; $display("FAIL tx_drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 16'h00A0 + 16'(i));
      end
      cycle();
    end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_drained_valid: got %b want 0", tx_valid); end
    drive(16'hF003, 16'h0, 1'b0); cycle();
    n_vec++; if (core_rdata !== 16'h0009) begin n_err++; $display("FAIL tx_status_empty: got %h want 0009", core_rdata); end
    drive(16'hF003, 16'h0008, 1'b1); cycle();
    drive(16'hF003, 16'h0, 1'b0); cycle();
    n_vec++; if (core_rdata !== 16'h0001) begin n_err++; $display("FAIL tx_ovf_clear: got %h want 0001", core_rdata); end
  endtask

  task automatic test_push_pop();
    tx_ready = 1'b0;
    drive(16'hF000, 16'h00B0, 1'b1); cycle();
    drive(16'hF000, 16'h00B1, 1'b1); cycle();
    tx_ready = 1'b1;
    drive(16'hF000, 16'h00B2, 1'b1); cycle();
    tx_ready = 1'b0;
    drive(16'hF000, 16'h0, 1'b0); cycle();
    n_vec++; if (core_rdata !== 16'h0002) begin n_err++; $display("FAIL pushpop_count: got %h want 0002", core_rdata); end
    n_vec++; if (tx_data !== 16'h00B1) begin n_err++; $display("FAIL pushpop_head1: got %h want 00b1", tx_data); end
    tx_ready = 1'b1; drive(16'hF00F, 16'h0, 1'b0); cycle();
    n_vec++; if (tx_data !== 16'h00B2) begin n_err++; $display("FAIL pushpop_head2: got %h want 00b2", tx_data); end
    cycle();
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL pushpop_empty: got %b want 0", tx_valid); end
  endtask

  task automatic test_rx();
    drive(16'hF006, 16'h0001, 1'b1); cycle();
    rx_data = 16'hBEEF; rx_valid = 1'b1;
    drive(16'hF006, 16'h0, 1'b0); cycle();
    n_vec++; if (core_rdata !== 16'h0001) begin n_err++; $display("FAIL ctrl_read: got %h want 0001", core_rdata); end
    rx_valid = 1'b0;
    n_vec++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL rx_ready_full: got %b want 0", rx_ready); end
    drive(16'hF001, 16'h0, 1'b0); cycle();
    n_vec++; if (core_rdata !== 16'hBEEF) begin n_err++; $display("FAIL rx_hold: got %h want beef", core_rdata); end
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL rx_irq_set: got %b want 1", irq); end
    drive(16'hF002, 16'h0, 1'b1); cycle();
    n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL rx_clear_ready: got %b want 1", rx_ready); end
    drive(16'hF00F, 16'h0, 1'b0); cycle();
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rx_irq_clear: got %b want 0", irq); end
    // clear while a new word is already waiting: it lands one cycle later
    rx_data = 16'h1111; rx_valid = 1'b1; cycle();
    rx_data = 16'h2222;
    drive(16'hF002, 16'h0, 1'b1); cycle();
    n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL rx_coincide_ready: got %b want 1", rx_ready); end
    drive(16'hF001, 16'h0, 1'b0); cycle();
    n_vec++; if (core_rdata !== 16'h1111) begin n_err++; $display("FAIL rx_coincide_old: got %h want 1111", core_rdata); end
    rx_valid = 1'b0; cycle();
    n_vec++; if (core_rdata !== 16'h2222) begin n_err++; $display("FAIL rx_coincide_new: got %h want 2222", core_rdata); end
    drive(16'hF002, 16'h0, 1'b1); cycle();
    drive(16'hF006, 16'h0, 1'b1); cycle();
  endtask

  task automatic test_tgn_reset();
    drive(16'hF005, 16'h0055, 1'b1); cycle();
    n_vec++; if (tgn_reg !== 16'h0055) begin n_err++; $display("FAIL tgn_write: got %h want 0055", tgn_reg); end
    tx_ready = 1'b0;
    drive(16'hF000, 16'h00C0, 1'b1); cycle();
    rx_data = 16'h3333; rx_valid = 1'b1;
    drive(16'hF00F, 16'h0, 1'b0); cycle();
    rx_valid = 1'b0;
    reset = 1'b1; cycle();
    n_vec++; if (tgn_reg !== 16'h0) begin n_err++; $display("FAIL rst_tgn: got %h want 0000", tgn_reg); end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_txvalid: got %b want 0", tx_valid); end
    n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL rst_rxready: got %b want 1", rx_ready); end
    cycle();
    reset = 1'b0;
    drive(16'hF004, 16'h0, 1'b0); cycle();
    n_vec++; if (core_rdata !== 16'h0 || tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_timer0: got %h v=%b want 0000 v=0", core_rdata, tx_valid); end
    cycle();
    n_vec++; if (core_rdata !== 16'h0001 || tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_timer1: got %h v=%b want 0001 v=0", core_rdata, tx_valid); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 16; i++) begin drive(16'(i), 16'($urandom), 1'b1); cycle(); end
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 4) a = {4'($urandom_range(0, 14)), 8'h00, 4'($urandom)};
      else                           a = 16'hF000 + 16'($urandom_range(0, 8));
      drive(a, 16'($urandom), ($urandom_range(0, 2) == 0));
      tx_ready = $urandom_range(0, 1) == 1;
      rx_valid = $urandom_range(0, 9) < 3;
      rx_data  = 16'($urandom);
      cycle();
      n_vec++; if (core_rdata !== m_rd) begin n_err++; $display("FAIL rnd_rdata@%0d: got %h want %h", n, core_rdata, m_rd); end
      n_vec++; if (tx_valid !== (txq.size() > 0)) begin n_err++; $display("FAIL rnd_txvalid@%0d: got %b want %b", n, tx_valid, txq.size() > 0); end
      if (txq.size() > 0) begin
        n_vec++; if (tx_data !== txq[0]) begin n_err++; $display("FAIL rnd_txdata@%0d: got %h want %h", n, tx_data, txq[0]); end
      end
      n_vec++; if (rx_ready !== !m_rxf) begin n_err++; $display("FAIL rnd_rxready@%0d: got %b want %b", n, rx_ready, !m_rxf); end
      n_vec++; if (irq !== m_irq) begin n_err++; $display("FAIL rnd_irq@%0d: got %b want %b", n, irq, m_irq); end
      n_vec++; if (tgn_reg !== m_tgn) begin n_err++; $display("FAIL rnd_tgn@%0d: got %h want %h", n, tgn_reg, m_tgn); end
    end
  endtask

  initial begin
    test_reset();
    test_ram_alias();
    test_tx_overflow();
    test_push_pop();
    test_rx();
    test_tgn_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
